jsv_param_fetch_arbiter: RTL and testbench

Sits between the 4-word x 32-bit single-port Julia parameter RAM and its two users: the processor's Avalon-MM slave path and the fractal engine. The processor accesses individual words with waitrequest back-pressure. On each frame_start the block fetches all four words atomically into a shadow register bank, giving the fractal engine a tear-free parameter snapshot for the whole frame. Contention is arbitrated round-robin at transaction granularity.

---
 rtl/jsv_param_fetch_arbiter.sv | 163 ++++++++++++++++
 tb/tb_jsv_param_fetch_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jsv_param_fetch_arbiter.sv
// jsv_param_fetch_arbiter
// Arbitrates the single-port Julia parameter RAM between the CPU Avalon-MM
// slave path and an atomic 4-word snapshot fetch for the fractal engine.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   cpu_*               - Avalon-MM slave (word access, waitrequest, 1-cycle read)
//   frame_start         - snapshot request pulse
//   fetch_busy          - snapshot pending / running / last capture in flight
//   params              - snapshot, word k at [k*DATA_W +: DATA_W]
//   params_update       - one-cycle pulse when params changes
//   params_loaded       - sticky, a snapshot has completed since reset
//   mem_*               - RAM port (registered address, 1-cycle read latency)
module jsv_param_fetch_arbiter #(
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDR_W-1:0]           cpu_address,
  input  logic                        cpu_chipselect,
  input  logic                        cpu_read,
  input  logic                        cpu_write,
  input  logic [DATA_W-1:0]           cpu_writedata,
  input  logic [DATA_W/8-1:0]         cpu_byteenable,
  output logic                        cpu_waitrequest,
  output logic [DATA_W-1:0]           cpu_readdata,
  output logic                        cpu_readdatavalid,
  input  logic                        frame_start,
  output logic                        fetch_busy,
  output logic [NUM_WORDS*DATA_W-1:0] params,
  output logic                        params_update,
  output logic                        params_loaded,
  output logic [ADDR_W-1:0]           mem_address,
  output logic                        mem_chipselect,
  output logic                        mem_write,
  output logic [DATA_W-1:0]           mem_writedata,
  output logic [DATA_W/8-1:0]         mem_byteenable,
  output logic                        mem_clken,
  input  logic [DATA_W-1:0]           mem_readdata
);

  typedef enum logic {S_IDLE, S_FETCH} state_t;
  typedef enum logic {G_CPU, G_FETCH} grant_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  state_t                            state_q, state_d;
  grant_t                            last_q, last_d;
  logic [ADDR_W-1:0]                 cnt_q, cnt_d;
  logic                              pend_q, pend_d;
  logic                              cap_v_q, cap_v_d;
  logic [ADDR_W-1:0]                 cap_idx_q, cap_idx_d;
  logic                              rd_v_q, rd_v_d;
  logic [NUM_WORDS-2:0][DATA_W-1:0]  staging_q;
  logic [NUM_WORDS*DATA_W-1:0]       params_q;
  logic                              update_q, loaded_q;
  logic                              cpu_req, gnt_cpu, gnt_fetch;

  assign cpu_req = cpu_chipselect & (cpu_read | cpu_write);

  always_comb begin
    gnt_cpu        = 1'b0;
    gnt_fetch      = 1'b0;
    state_d        = state_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    mem_address    = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    mem_byteenable = '0;

    if (state_q == S_IDLE) begin
      // Round-robin on contention: the side not served last time wins.
      if (cpu_req && pend_q) begin
        if (last_q == G_FETCH) gnt_cpu = 1'b1;
        else                   gnt_fetch = 1'b1;
      end else if (cpu_req) begin
        gnt_cpu = 1'b1;
      end else if (pend_q) begin
        gnt_fetch = 1'b1;
      end
    end

    if (gnt_cpu) begin
      last_d         = G_CPU;
      mem_chipselect = 1'b1;
      mem_address    = cpu_address;
      mem_byteenable = cpu_byteenable;
      if (cpu_write) begin
        mem_write     = 1'b1;
        mem_writedata = cpu_writedata;
      end
    end else if (gnt_fetch) begin
      // Word 0 is issued in the grant cycle itself; FETCH covers words 1..3.
      last_d         = G_FETCH;
      state_d        = S_FETCH;
      cnt_d          = ADDR_W'(1);
      mem_chipselect = 1'b1;
      mem_byteenable = '1;
    end else if (state_q == S_FETCH) begin
      mem_chipselect = 1'b1;
      mem_address    = cnt_q;
      mem_byteenable = '1;
      cnt_d          = cnt_q + ADDR_W'(1);
      if (cnt_q == LAST) state_d = S_IDLE;
    end

    pend_d    = frame_start | (pend_q & ~gnt_fetch);
    cap_v_d   = gnt_fetch | (state_q == S_FETCH);
    cap_idx_d = mem_address;
    rd_v_d    = gnt_cpu & ~cpu_write;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      last_q    <= G_FETCH;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      cap_v_q   <= 1'b0;
      cap_idx_q <= '0;
      rd_v_q    <= 1'b0;
      staging_q <= '0;
      params_q  <= '0;
      update_q  <= 1'b0;
      loaded_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      cap_v_q   <= cap_v_d;
      cap_idx_q <= cap_idx_d;
      rd_v_q    <= rd_v_d;
      update_q  <= 1'b0;
      if (cap_v_q) begin
        // The last word goes straight into params together with the staged
        // words, so the snapshot is committed whole in a single edge.
        if (cap_idx_q == LAST) begin
          params_q <= {mem_readdata, staging_q};
          update_q <= 1'b1;
          loaded_q <= 1'b1;
        end else begin
          for (int unsigned k = 0; k < NUM_WORDS - 1; k++) begin
            if (cap_idx_q == ADDR_W'(k)) staging_q[k] <= mem_readdata;
          end
        end
      end
    end
  end

  assign cpu_waitrequest   = ~gnt_cpu;
  assign cpu_readdatavalid = rd_v_q;
  assign cpu_readdata      = rd_v_q ? mem_readdata : '0;
  assign fetch_busy        = pend_q | (state_q == S_FETCH) | cap_v_q;
  assign params            = params_q;
  assign params_update     = update_q;
  assign params_loaded     = loaded_q;
  assign mem_clken         = 1'b1;

endmodule

// File: tb/tb_jsv_param_fetch_arbiter.sv
module tb_jsv_param_fetch_arbiter;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   cpu_address = '0;
  logic         cpu_chipselect = 1'b0, cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0]  cpu_writedata = '0;
  logic [3:0]   cpu_byteenable = '0;
  logic         cpu_waitrequest, cpu_readdatavalid;
  logic [31:0]  cpu_readdata;
  logic         frame_start = 1'b0;
  logic         fetch_busy, params_update, params_loaded;
  logic [127:0] params;
  logic [1:0]   mem_address;
  logic         mem_chipselect, mem_write, mem_clken;
  logic [31:0]  mem_writedata, mem_readdata;
  logic [3:0]   mem_byteenable;

  jsv_param_fetch_arbiter #(.ADDR_W(2), .DATA_W(32), .NUM_WORDS(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_chipselect(cpu_chipselect),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .cpu_readdatavalid(cpu_readdatavalid),
    .frame_start(frame_start), .fetch_busy(fetch_busy),
    .params(params), .params_update(params_update), .params_loaded(params_loaded),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // RAM model: registered address, 1-cycle read latency, byte enables.
  logic [31:0] ram [4];
  logic [31:0] ram_q = '0;
  initial for (int i = 0; i < 4; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end
      ram_q <= ram[mem_address];
    end
  end
  assign mem_readdata = ram_q;

  int n_cmp = 0;
  int n_bad = 0;
  int n_upd = 0;
  int cyc   = 0;
  logic [31:0]  rd_exp [$];
  logic [127:0] pr_exp [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every DUT read return and snapshot update against the queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (cpu_readdatavalid) begin
        if (rd_exp.size() == 0) check("unexpected_readdatavalid", 1, 0);
        else check("cpu_readdata", cpu_readdata, rd_exp.pop_front());
      end
      if (params_update) begin
        n_upd++;
        if (pr_exp.size() == 0) check("unexpected_params_update", 1, 0);
        else check("params", params, pr_exp.pop_front());
      end
    end
  end

  task automatic cpu_xfer(input bit wr, input logic [1:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int waits, output int acc_cyc);
    bit ok = 0;
    waits = 0;
    acc_cyc = 0;
    @(posedge clk); #1;
    cpu_chipselect = 1; cpu_write = wr; cpu_read = !wr;
    cpu_address = a; cpu_writedata = d; cpu_byteenable = be;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!cpu_waitrequest) begin ok = 1; acc_cyc = cyc; end
      else waits++;
    end
    if (!ok) check("cpu_accept_timeout", 0, 1);
    @(posedge clk); #1;
    cpu_chipselect = 0; cpu_write = 0; cpu_read = 0;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    int w, c;
    cpu_xfer(1, a, d, be, w, c);
  endtask

  task automatic pulse_fs();
    @(posedge clk); #1 frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
  endtask

  task automatic wait_quiet();
    bit done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (!fetch_busy && rd_exp.size() == 0 && pr_exp.size() == 0) done = 1;
    end
    if (!done) check("quiet_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int w, c, u0;

    // Reset state
    #12;
    check("rst_params", params, 0);
    check("rst_loaded", params_loaded, 0);
    check("rst_waitreq", cpu_waitrequest, 1);
    check("rst_busy", fetch_busy, 0);
    check("rst_rdvalid", cpu_readdatavalid, 0);
    check("rst_clken", mem_clken, 1);
    check("rst_mem_cs", mem_chipselect, 0);
    #10 reset_n = 1;

    // Fill words, snapshot, verify address sequence and latency
    cpu_wr(0, 32'h11111111, 4'hF);
    cpu_wr(1, 32'h22222222, 4'hF);
    cpu_wr(2, 32'h33333333, 4'hF);
    cpu_wr(3, 32'h44444444, 4'hF);
    @(posedge clk); #1 frame_start = 1;
    pr_exp.push_back(128'h44444444_33333333_22222222_11111111);
    @(negedge clk);
    @(posedge clk); #1 frame_start = 0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk); else @(negedge clk);
      check($sformatf("fetch_addr%0d", k), mem_address, k);
      check($sformatf("fetch_cs%0d", k), {mem_chipselect, mem_write, cpu_waitrequest, mem_byteenable}, 7'b1_0_1_1111);
    end
    @(negedge clk);
    check("update_early", params_update, 0);
    @(negedge clk);
    check("update_T6", params_update, 1);
    check("loaded_set", params_loaded, 1);
    wait_quiet();

    // Uncontended read of word 2
    cpu_wr(2, 32'hDEADBEEF, 4'hF);
    rd_exp.push_back(32'hDEADBEEF);
    fork
      cpu_xfer(0, 2, 0, 4'hF, w, c);
      begin
        @(posedge clk); @(negedge clk);
        @(negedge clk);
        check("rd_valid_next", cpu_readdatavalid, 1);
      end
    join
    check("rd_waits", w, 0);
    wait_quiet();

    // Reset in the middle of a fetch (after two addresses)
    u0 = n_upd;
    pulse_fs();
    @(negedge clk); @(negedge clk);
    #2 reset_n = 0;
    #1;
    check("midrst_params", params, 0);
    check("midrst_loaded", params_loaded, 0);
    check("midrst_busy", fetch_busy, 0);
    check("midrst_waitreq", cpu_waitrequest, 1);
    @(negedge clk); #1 reset_n = 1;
    repeat (10) @(negedge clk);
    check("midrst_no_update", n_upd - u0, 0);

    // frame_start coincident with CPU write after reset: CPU first
    pr_exp.push_back(128'h44444444_DEADBEEF_CAFEF00D_11111111);
    fork
      pulse_fs();
      cpu_xfer(1, 1, 32'hCAFEF00D, 4'hF, w, c);
    join
    check("coinc_cpu_first", w, 0);
    wait_quiet();

    // Two frame_starts during a fetch with a CPU read waiting
    u0 = n_upd;
    pr_exp.push_back(128'h44444444_DEADBEEF_CAFEF00D_11111111);
    pr_exp.push_back(128'h44444444_DEADBEEF_CAFEF00D_11111111);
    rd_exp.push_back(32'h44444444);
    @(posedge clk); #1 frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
    fork
      cpu_xfer(0, 3, 0, 4'hF, w, c);
      begin
        @(posedge clk); #1 frame_start = 1;
        @(posedge clk); #1 frame_start = 0;
        @(posedge clk); #1 frame_start = 1;
        @(posedge clk); #1 frame_start = 0;
      end
      begin
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
          @(negedge clk);
          if (!cpu_waitrequest) begin
            seen = 1;
            check("between_fetch_pending", fetch_busy, 1);
          end
        end
      end
    join
    check("between_one_wait_fetch", w > 0, 1);
    wait_quiet();
    check("double_fs_updates", n_upd - u0, 2);

    // Byte-enable write
    cpu_wr(0, 32'h12345678, 4'hF);
    cpu_wr(0, 32'h0000AB00, 4'b0010);
    pr_exp.push_back(128'h44444444_DEADBEEF_CAFEF00D_1234AB78);
    pulse_fs();
    wait_quiet();

    check("rd_queue_empty", rd_exp.size(), 0);
    check("pr_queue_empty", pr_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
